i_buf_controller: RTL and testbench

Video capture front end: samples an incoming RAW8 video stream (vsync, data enable, 8-bit pixel) on pclk. Packs 4 consecutive pixels per 32-bit word and writes the words into a linebuffer. Pulses line/frame events so the Processing System can copy each completed line into the framebuffer. Input-side counterpart of the linebuffer-to-video output path; uses the same word format, first pixel in bits [31:24].

---
 rtl/i_buf_controller.sv | 109 ++++++++++
 tb/tb_i_buf_controller.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/i_buf_controller.sv
// i_buf_controller: packs a RAW8 video stream four pixels per word into a linebuffer and pulses line/frame events.
// Optional macro I_BUF_PARTIAL_FLUSH_EN writes the trailing partial word of a short line.
module i_buf_controller #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DISPLAY_WIDTH  = 640,
    parameter int DISPLAY_HEIGHT = 480
) (
    input  logic                     pclk,
    input  logic                     reset_n,
    input  logic                     i_vsync,
    input  logic                     i_vde,
    input  logic [7:0]               i_data,
    output logic [ADDRESS_WIDTH-1:0] addr,
    output logic [31:0]              o_data,
    output logic                     wr_en,
    output logic                     line_ready,
    output logic                     frame_ready,
    output logic [12:0]              line_count,
    output logic                     err_line_len
);
    localparam int CW = $clog2(DISPLAY_WIDTH + 2);
    localparam logic [CW-1:0] W_C = CW'(DISPLAY_WIDTH);
    localparam logic [CW-1:0] W_OVER = CW'(DISPLAY_WIDTH + 1);
    localparam logic [12:0] H_C = 13'(DISPLAY_HEIGHT);

    typedef enum logic [1:0] {WAIT_FRAME, WAIT_LINE, ACTIVE, LINE_DONE} state_t;

    state_t          state_q;
    logic            vsync_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [23:0]     word_q;
    logic [31:0]     word_d;
    logic [12:0]     line_d;
    logic            frame_start;

    assign frame_start = vsync_q & ~i_vsync;
    assign cnt_d       = cnt_q + CW'(1);
    assign word_d      = {word_q, i_data};
    assign line_d      = line_count + 13'd1;

    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            state_q      <= WAIT_FRAME;
            vsync_q      <= 1'b1;
            cnt_q        <= '0;
            word_q       <= '0;
            addr         <= '0;
            o_data       <= '0;
            wr_en        <= 1'b0;
            line_ready   <= 1'b0;
            frame_ready  <= 1'b0;
            line_count   <= '0;
            err_line_len <= 1'b0;
        end else begin
            vsync_q      <= i_vsync;
            wr_en        <= 1'b0;
            line_ready   <= 1'b0;
            frame_ready  <= 1'b0;
            err_line_len <= 1'b0;
            if (wr_en) addr <= addr + ADDRESS_WIDTH'(1);
            if (frame_start) begin
                state_q    <= WAIT_LINE;
                line_count <= '0;
                addr       <= '0;
                cnt_q      <= '0;
            end else begin
                case (state_q)
                    WAIT_FRAME: ;
                    WAIT_LINE: if (i_vde) begin
                        state_q <= ACTIVE;
                        word_q  <= word_d[23:0];
                        cnt_q   <= CW'(1);
                    end
                    ACTIVE: if (!i_vde) begin
                        state_q      <= LINE_DONE;
                        line_ready   <= 1'b1;
                        err_line_len <= cnt_q != W_C;
                        line_count   <= line_d;
                        frame_ready  <= line_d == H_C;
                        cnt_q        <= '0;
                        addr         <= '0;
`ifdef I_BUF_PARTIAL_FLUSH_EN
                        // the last full word's address bump already happened, so addr is the next index
                        if (cnt_q[1:0] != 2'b00 && cnt_q <= W_C) begin
                            wr_en  <= 1'b1;
                            o_data <= {word_q, 8'h00} << {~cnt_q[1:0], 3'b000};
                            addr   <= addr;
                        end
`endif
                    end else if (cnt_q < W_C) begin
                        cnt_q  <= cnt_d;
                        word_q <= word_d[23:0];
                        if (cnt_d[1:0] == 2'b00) begin
                            wr_en  <= 1'b1;
                            o_data <= word_d;
                        end
                    end else begin
                        cnt_q <= W_OVER;
                    end
                    LINE_DONE: begin
                        state_q <= (line_count == H_C) ? WAIT_FRAME : WAIT_LINE;
                        addr    <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i_buf_controller.sv
// tb_i_buf_controller: directed checks of i_buf_controller with an 8-pixel, 2-line geometry.
module tb_i_buf_controller;
    localparam int W = 8;
    localparam int H = 2;
`ifdef I_BUF_PARTIAL_FLUSH_EN
    localparam logic FL = 1'b1;
`else
    localparam logic FL = 1'b0;
`endif

    logic        pclk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_vsync = 1'b1;
    logic        i_vde = 1'b0;
    logic [7:0]  i_data = 8'h00;
    logic [31:0] addr;
    logic [31:0] o_data;
    logic        wr_en;
    logic        line_ready;
    logic        frame_ready;
    logic [12:0] line_count;
    logic        err_line_len;

    int errors = 0;
    int checks = 0;
    int lrcnt = 0;
    int n0;
    int l0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    always #5 pclk = ~pclk;

    i_buf_controller #(.ADDRESS_WIDTH(32), .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H)) dut (
        .pclk(pclk), .reset_n(reset_n), .i_vsync(i_vsync), .i_vde(i_vde), .i_data(i_data),
        .addr(addr), .o_data(o_data), .wr_en(wr_en), .line_ready(line_ready),
        .frame_ready(frame_ready), .line_count(line_count), .err_line_len(err_line_len)
    );

    always @(negedge pclk) begin
        if (wr_en) begin
            wa.push_back(addr);
            wd.push_back(o_data);
        end
        if (line_ready) lrcnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic vs, input logic de, input logic [7:0] d);
        i_vsync = vs;
        i_vde = de;
        i_data = d;
        @(posedge pclk);
        #1;
    endtask

    task automatic pixels(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 8'(base + i));
    endtask

    task automatic vsync_pulse();
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_addr"}, addr, 0);
        chk({tag, "_odata"}, o_data, 0);
        chk({tag, "_ctl"}, {wr_en, line_ready, frame_ready, err_line_len}, 0);
        chk({tag, "_lcnt"}, 32'(line_count), 0);
    endtask

    initial begin
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
        chk_zero("reset");
        reset_n = 1'b1;
        n0 = wa.size();
        pixels(4, 8'h50);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
        chk("prevsync_writes", 32'(wa.size() - n0), 0);
        chk("prevsync_lr", 32'(lrcnt), 0);

        vsync_pulse();
        pixels(3, 8'h01);
        chk("t1_no_early_wr", 32'(wr_en), 0);
        cyc(1'b1, 1'b1, 8'h04);
        chk("t1_wr0", {31'd0, wr_en}, 1);
        chk("t1_addr0", addr, 0);
        chk("t1_data0", o_data, 32'h01020304);
        pixels(3, 8'h05);
        chk("t1_addr_inc", addr, 1);
        cyc(1'b1, 1'b1, 8'h08);
        chk("t1_wr1", {31'd0, wr_en}, 1);
        chk("t1_addr1", addr, 1);
        chk("t1_data1", o_data, 32'h05060708);
        cyc(1'b1, 1'b0, 8'h00);
        chk("t1_lr", {28'd0, line_ready, frame_ready, err_line_len, wr_en}, 32'b1000);
        chk("t1_lcnt", 32'(line_count), 1);
        chk("t1_addr_clr", addr, 0);
        cyc(1'b1, 1'b0, 8'h00);
        chk("t1_lr_pulse", 32'(line_ready), 0);

        pixels(8, 8'h11);
        cyc(1'b1, 1'b0, 8'h00);
        chk("t2_lr_fr", {30'd0, line_ready, frame_ready}, 32'b11);
        chk("t2_lcnt", 32'(line_count), 2);
        cyc(1'b1, 1'b0, 8'h00);
        chk("t2_fr_pulse", 32'(frame_ready), 0);
        chk("t2_writes", 32'(wd[3]), 32'h15161718);
        n0 = wa.size();
        l0 = lrcnt;
        pixels(8, 8'h21);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
        chk("t2_extra_line_wr", 32'(wa.size() - n0), 0);
        chk("t2_extra_line_lr", 32'(lrcnt - l0), 0);
        chk("t2_lcnt_hold", 32'(line_count), 2);

        vsync_pulse();
        chk("t3_lcnt_restart", 32'(line_count), 0);
        n0 = wa.size();
        pixels(6, 8'hA0);
        cyc(1'b1, 1'b0, 8'h00);
        chk("t3_lr_err", {30'd0, line_ready, err_line_len}, 32'b11);
        chk("t3_flush_wr", 32'(wr_en), 32'(FL));
        cyc(1'b1, 1'b0, 8'h00);
        chk("t3_nwrites", 32'(wa.size() - n0), 32'(1 + FL));
        chk("t3_data0", wd[n0], 32'hA0A1A2A3);
        chk("t3_last", wd[wd.size() - 1], FL ? 32'hA4A50000 : 32'hA0A1A2A3);
        chk("t3_last_addr", wa[wa.size() - 1], 32'(FL));

        n0 = wa.size();
        pixels(10, 8'hB0);
        cyc(1'b1, 1'b0, 8'h00);
        chk("t4_lr_fr_err", {29'd0, line_ready, frame_ready, err_line_len}, 32'b111);
        cyc(1'b1, 1'b0, 8'h00);
        chk("t4_nwrites", 32'(wa.size() - n0), 2);
        chk("t4_data1", wd[n0 + 1], 32'hB4B5B6B7);
        chk("t4_addr1", wa[n0 + 1], 1);

        vsync_pulse();
        n0 = wa.size();
        l0 = lrcnt;
        pixels(3, 8'hD0);
        cyc(1'b0, 1'b1, 8'hD3);
        chk("t5_lcnt", 32'(line_count), 0);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
        chk("t5_abort_wr", 32'(wa.size() - n0), 0);
        chk("t5_abort_lr", 32'(lrcnt - l0), 0);
        pixels(4, 8'hC0);
        cyc(1'b1, 1'b0, 8'h00);
        chk("t5_lcnt1", 32'(line_count), 1);
        cyc(1'b1, 1'b0, 8'h00);
        chk("t5_addr", wa[wa.size() - 1], 0);
        chk("t5_data", wd[wd.size() - 1], 32'hC0C1C2C3);

        vsync_pulse();
        pixels(2, 8'hE0);
        reset_n = 1'b0;
        cyc(1'b1, 1'b1, 8'hE2);
        chk_zero("t6_reset");
        reset_n = 1'b1;
        n0 = wa.size();
        pixels(4, 8'hF0);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
        chk("t6_no_wr", 32'(wa.size() - n0), 0);
        chk("t6_lcnt", 32'(line_count), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
